fft_sample_serializer: RTL and testbench
========================================

Name: fft_sample_serializer

Overview:
- Transmit side of the bit-serial sample link between FFT test stimulus and the DUT's flop-based capture chain.
- Accepts one complex sample (I and Q concatenated) per valid/ready handshake and shifts it out one bit per clk.
- Drives a frame strobe on the first bit so the downstream receiver can align.
- Supports back-to-back frames with no idle gap.

Parameters:
- DATA_W, 16: width of each I and Q component; the parallel word is 2*DATA_W bits.
- MSB_FIRST, 1: 1 sends in_data[2*DATA_W-1] first; 0 sends in_data[0] first.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- arstb  input  1  asynchronous active-low reset
- rstb  input  1  synchronous active-low clear, sampled on the rising edge of clk
- in_valid  input  1  parallel sample available
- in_ready  output  1  serializer can accept in_data this cycle
- in_data  input  2*DATA_W  {I, Q}; I occupies the upper DATA_W bits
- sout  output  1  serial data bit
- sframe  output  1  high during the first bit of each frame
- sbusy  output  1  high while a frame is on sout
- done  output  1  one-cycle pulse during the last bit of a frame

Behaviour:
- Reset:
  - Reset is arstb: asynchronous, active-low. Clock is clk.
  - arstb low forces state=IDLE and clears shift register and counter. Outputs during reset: sout=0, sframe=0, sbusy=0, done=0, in_ready=0.
  - rstb low at a rising edge has the same effect synchronously. arstb has priority over rstb.
- Frame:
  - FRAME_LEN = 2*DATA_W, or 2*DATA_W+1 with the optional parity feature.
  - The bit counter is $clog2(FRAME_LEN+1) wide.
- IDLE:
  - in_ready=1, sout=0, sbusy=0.
  - If in_valid=1 at an edge, load the shift register with in_data, set cnt=0, go to SHIFT.
- SHIFT:
  - sout = current head bit of the shift register. sframe=1 when cnt==0. sbusy=1.
  - Each edge shifts the register one position toward the head; MSB_FIRST selects the direction. cnt increments.
  - Last bit (cnt==FRAME_LEN-1): done=1 and in_ready=1.
    - If in_valid=1 at that edge, load the new word, set cnt=0, stay in SHIFT. The next cycle has sframe=1, giving zero gap.
    - Otherwise go to IDLE.
  - in_ready=0 on every other SHIFT cycle. in_valid is ignored there, and in_data need not be held stable after acceptance.
- Latency: the first bit appears on sout in the cycle immediately after the accepting edge. The frame occupies exactly FRAME_LEN consecutive cycles.
- Reset mid-frame: the frame is abandoned with no partial done. Outputs return to reset values. The next accept starts a fresh frame.
- in_valid deasserted during IDLE: no change, sout held at 0.
- All outputs are registered except in_ready and done, which are decoded from the registered state and counter.

Optional Feature:
- Macro: FFT_SER_PARITY_EN.
- Defined:
  - One extra bit, the even parity (XOR of all 2*DATA_W bits of the accepted word), is sent after the last data bit. FRAME_LEN=2*DATA_W+1.
  - Parity is computed and stored at the accept edge.
  - done and in_ready assert on the parity-bit cycle instead of the last data bit.
- Undefined: no parity logic is present; FRAME_LEN=2*DATA_W.

Decomposition:
- Package fft_ser_pkg holds:
  - state enum {IDLE, SHIFT}
  - localparam function frame_len(DATA_W, parity_en)
  - localparam CNT_W derived via $clog2
- Sub-module ser_bit_counter: modulo-FRAME_LEN up-counter with clear/load, enable, and a registered terminal-count flag. It is reusable by the matching deserializer.
- Shift register, parity and FSM stay inline in fft_sample_serializer.

Test Plan (DATA_W=16, MSB_FIRST=1 unless noted):
- Single frame: in_data=32'hA5A5_0F0F, one-cycle in_valid -> sout = 1010_0101_1010_0101_0000_1111_0000_1111 over 32 cycles; sframe only on bit 0; done only on bit 31; in_ready=0 during bits 0–30.
- Back-to-back: in_valid held high with 32'hFFFF_0000 then 32'h0000_FFFF -> 64 contiguous bits, sframe at cycles 0 and 32, no idle cycle, sbusy continuously 1.
- LSB-first (MSB_FIRST=0): in_data=32'h0000_0001 -> sout=1 on bit 0, then 31 zeros.
- Reset mid-frame: arstb pulsed low at bit 10 of 32'hFFFF_FFFF -> sout, sbusy and sframe go 0 immediately; no done pulse. Next accept restarts at bit 0 with sframe=1. Repeat with rstb (outputs clear at the next edge).
- Idle hold: in_valid=0 for 20 cycles after reset -> in_ready=1, sout=0, sbusy=0, no sframe or done.
- Parity (FFT_SER_PARITY_EN defined): 32'h0000_0001 -> 33-bit frame with bit 32=1, done on bit 32; 32'h0000_0003 -> bit 32=0.

Source files
------------

// File: rtl/fft_ser_pkg.sv
// Shared types and frame-geometry helpers for the bit-serial sample link.
// Build macro FFT_SER_PARITY_EN appends an even-parity bit to every frame.
package fft_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

`ifdef FFT_SER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Bits on the wire per sample: I and Q, plus the optional parity bit.
  function automatic int unsigned frame_len(input int unsigned data_w, input bit parity_en);
    return (2 * data_w) + (parity_en ? 32'd1 : 32'd0);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned flen);
    return 32'($clog2(flen + 1));
  endfunction

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned CNT_W      = cnt_width(frame_len(DEF_DATA_W, PARITY_EN));

endpackage

// File: rtl/ser_bit_counter.sv
// Modulo-MOD bit-position counter with synchronous clear and a registered
// terminal-count flag; shared with the matching deserializer.
module ser_bit_counter #(
  parameter int unsigned MOD   = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             arstb,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);

  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (en) begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  // tc is computed from the next count so it is aligned with cnt, not a cycle late.
  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      tc  <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/fft_sample_serializer.sv
// Parallel-to-serial transmitter: one {I,Q} word per handshake, one bit per clk,
// frame strobe on bit 0, zero-gap chaining. Build macro: FFT_SER_PARITY_EN.
module fft_sample_serializer
  import fft_ser_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                arstb,
  input  logic                rstb,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_data,
  output logic                sout,
  output logic                sframe,
  output logic                sbusy,
  output logic                done
);

  localparam int unsigned FRAME_LEN = frame_len(DATA_W, PARITY_EN);
  localparam int unsigned FCNT_W    = cnt_width(FRAME_LEN);

  ser_state_e           state;
  logic [FRAME_LEN-1:0] sr;
  logic [FRAME_LEN-1:0] load_word;
  logic [FRAME_LEN-1:0] sr_shift;
  logic                 load_head;
  logic                 shift_head;
  logic                 accept;
  logic                 last;
  logic [FCNT_W-1:0]    cnt;
  logic                 tc;

  // Parity travels in the tail of the shift register so it falls out after the data.
  always_comb begin
    load_word = '0;
`ifdef FFT_SER_PARITY_EN
    if (MSB_FIRST) begin
      load_word = {in_data, ^in_data};
    end else begin
      load_word = {^in_data, in_data};
    end
`else
    load_word = in_data;
`endif
  end

  always_comb begin
    sr_shift   = '0;
    load_head  = 1'b0;
    shift_head = 1'b0;
    if (MSB_FIRST) begin
      sr_shift   = {sr[FRAME_LEN-2:0], 1'b0};
      load_head  = load_word[FRAME_LEN-1];
      shift_head = sr_shift[FRAME_LEN-1];
    end else begin
      sr_shift   = {1'b0, sr[FRAME_LEN-1:1]};
      load_head  = load_word[0];
      shift_head = sr_shift[0];
    end
  end

  // in_ready is gated by arstb so it reads 0 while the link is held in reset.
  assign last     = (state == SHIFT) && tc;
  assign done     = (state == SHIFT) && (cnt == FCNT_W'(FRAME_LEN - 1));
  assign in_ready = arstb && ((state == IDLE) || last);
  assign accept   = in_valid && in_ready;

  ser_bit_counter #(
    .MOD  (FRAME_LEN),
    .CNT_W(FCNT_W)
  ) u_cnt (
    .clk  (clk),
    .arstb(arstb),
    .clr  (!rstb || accept),
    .en   (state == SHIFT),
    .cnt  (cnt),
    .tc   (tc)
  );

  // sout always mirrors the head of sr while busy and is forced low otherwise.
  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      state  <= IDLE;
      sr     <= '0;
      sout   <= 1'b0;
      sframe <= 1'b0;
      sbusy  <= 1'b0;
    end else if (!rstb) begin
      state  <= IDLE;
      sr     <= '0;
      sout   <= 1'b0;
      sframe <= 1'b0;
      sbusy  <= 1'b0;
    end else if (accept) begin
      state  <= SHIFT;
      sr     <= load_word;
      sout   <= load_head;
      sframe <= 1'b1;
      sbusy  <= 1'b1;
    end else if ((state == SHIFT) && !last) begin
      state  <= SHIFT;
      sr     <= sr_shift;
      sout   <= shift_head;
      sframe <= 1'b0;
      sbusy  <= 1'b1;
    end else begin
      state  <= IDLE;
      sr     <= '0;
      sout   <= 1'b0;
      sframe <= 1'b0;
      sbusy  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_sample_serializer.sv
// Directed self-checking bench: MSB-first and LSB-first serializers on shared inputs.
module tb_fft_sample_serializer;

`ifdef FFT_SER_PARITY_EN
  localparam int FL = 33;
`else
  localparam int FL = 32;
`endif

  logic        clk;
  logic        arstb;
  logic        rstb;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready_m, sout_m, sframe_m, sbusy_m, done_m;
  logic        in_ready_l, sout_l, sframe_l, sbusy_l, done_l;

  int checks   = 0;
  int failures = 0;

  fft_sample_serializer #(.DATA_W(16), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .arstb(arstb), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_data(in_data), .sout(sout_m), .sframe(sframe_m), .sbusy(sbusy_m), .done(done_m)
  );

  fft_sample_serializer #(.DATA_W(16), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .arstb(arstb), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_data(in_data), .sout(sout_l), .sframe(sframe_l), .sbusy(sbusy_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag, input logic exp_ready);
    chk({tag, " in_ready"}, 32'(in_ready_m), 32'(exp_ready));
    chk({tag, " sout"},     32'(sout_m),     32'd0);
    chk({tag, " sframe"},   32'(sframe_m),   32'd0);
    chk({tag, " sbusy"},    32'(sbusy_m),    32'd0);
    chk({tag, " done"},     32'(done_m),     32'd0);
  endtask

  // Expects w to be accepted at the next edge; chain=1 offers nxt at the last bit.
  task automatic check_frame(input string tag, input logic [31:0] w,
                             input logic [31:0] nxt, input bit chain);
    logic exp_m, exp_l, par, is_last;
    par = ^w;
    for (int i = 0; i < FL; i++) begin
      tick();
      if (i == 0) begin
        in_valid = chain;
        in_data  = chain ? nxt : 32'hDEAD_BEEF;
      end
      exp_m   = (i < 32) ? w[31-i] : par;
      exp_l   = (i < 32) ? w[i]    : par;
      is_last = (i == FL - 1);
      chk($sformatf("%s b%0d sout_msb", tag, i),   32'(sout_m),     32'(exp_m));
      chk($sformatf("%s b%0d sout_lsb", tag, i),   32'(sout_l),     32'(exp_l));
      chk($sformatf("%s b%0d sframe", tag, i),     32'(sframe_m),   32'(i == 0));
      chk($sformatf("%s b%0d done", tag, i),       32'(done_m),     32'(is_last));
      chk($sformatf("%s b%0d in_ready", tag, i),   32'(in_ready_m), 32'(is_last));
      chk($sformatf("%s b%0d sbusy", tag, i),      32'(sbusy_m),    32'd1);
      chk($sformatf("%s b%0d sframe_lsb", tag, i), 32'(sframe_l),   32'(i == 0));
      chk($sformatf("%s b%0d done_lsb", tag, i),   32'(done_l),     32'(is_last));
    end
  endtask

  initial begin
    arstb    = 1'b0;
    rstb     = 1'b1;
    in_valid = 1'b0;
    in_data  = 32'h0;

    // Reset values
    #2;
    chk_quiet("reset", 1'b0);
    tick();
    tick();
    chk_quiet("reset held", 1'b0);
    arstb = 1'b1;

    // Idle hold
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_quiet($sformatf("idle c%0d", i), 1'b1);
    end

    // Single frame
    in_valid = 1'b1;
    in_data  = 32'hA5A5_0F0F;
    check_frame("single", 32'hA5A5_0F0F, 32'h0, 1'b0);
    tick();
    chk_quiet("after single", 1'b1);

    // Back-to-back frames
    in_valid = 1'b1;
    in_data  = 32'hFFFF_0000;
    check_frame("b2b0", 32'hFFFF_0000, 32'h0000_FFFF, 1'b1);
    check_frame("b2b1", 32'h0000_FFFF, 32'h0, 1'b0);
    tick();
    chk_quiet("after b2b", 1'b1);

    // LSB-first pattern and parity-odd word
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    check_frame("one", 32'h0000_0001, 32'h0, 1'b0);
    tick();
    in_valid = 1'b1;
    in_data  = 32'h0000_0003;
    check_frame("three", 32'h0000_0003, 32'h0, 1'b0);
    tick();
    chk_quiet("after three", 1'b1);

    // Asynchronous reset at bit 10
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    for (int i = 0; i <= 10; i++) begin
      tick();
      if (i == 0) in_valid = 1'b0;
      chk($sformatf("arst pre b%0d sout", i), 32'(sout_m), 32'd1);
      chk($sformatf("arst pre b%0d done", i), 32'(done_m), 32'd0);
    end
    arstb = 1'b0;
    #1;
    chk_quiet("arst mid", 1'b0);
    tick();
    chk_quiet("arst mid held", 1'b0);
    arstb = 1'b1;
    tick();
    chk_quiet("arst released", 1'b1);
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    check_frame("post_arst", 32'hFFFF_FFFF, 32'h0, 1'b0);
    tick();

    // Synchronous clear at bit 10
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    for (int i = 0; i <= 10; i++) begin
      tick();
      if (i == 0) in_valid = 1'b0;
      chk($sformatf("srst pre b%0d sout", i), 32'(sout_m), 32'd1);
    end
    rstb = 1'b0;
    #1;
    chk("srst before edge sbusy", 32'(sbusy_m), 32'd1);
    tick();
    chk_quiet("srst applied", 1'b1);
    rstb = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hA5A5_0F0F;
    check_frame("post_srst", 32'hA5A5_0F0F, 32'h0, 1'b0);
    tick();
    chk_quiet("final idle", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
